// File: rtl/cpu_sequencer.sv
// Multi-cycle phase sequencer for the 16-bit RISC: owns the instruction register and
// turns the decoder's level controls into per-phase strobes for datapath, PC and memory.
module cpu_sequencer #(
    parameter int IW    = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IW-1:0]    mem_rdata,
    input  logic             mem_ready,
    input  logic             dec_reg_we,
    input  logic             dec_mem_we,
    input  logic             dec_mem_addr_sel,
    input  logic             dec_jump,
    input  logic             dec_branch,
    input  logic             dec_halt,
    input  logic             alu_zero,
    output logic [3:0]       opcode_out,
    output logic [IW-1:0]    ir,
    output logic             mem_addr_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic             illegal_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IW-1:0]    ir_r;
    logic [CNT_W-1:0] retired_r;
    logic             halted_r;
    logic             load_ir_s;
    logic             retire_s;

    // State, instruction register, retired counter and halt flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            ir_r      <= {IW{1'b0}};
            retired_r <= {CNT_W{1'b0}};
            halted_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            halted_r <= (state_nxt_s == S_HALT);
            if (load_ir_s) begin
                ir_r <= mem_rdata;
            end else begin
                ir_r <= ir_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Next-state and phase strobes from the registered state and current decode
    always_comb begin
        state_nxt_s  = state_r;
        load_ir_s    = 1'b0;
        retire_s     = 1'b0;
        mem_req      = 1'b0;
        mem_addr_sel = 1'b0;
        mem_we       = 1'b0;
        reg_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        illegal_op   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    load_ir_s   = 1'b1;
                    pc_we       = 1'b1;
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                state_nxt_s = S_EXEC;
            end
            S_EXEC: begin
                if (dec_halt) begin
                    state_nxt_s = S_HALT;
                    retire_s    = 1'b1;
                end else if (dec_mem_addr_sel) begin
                    state_nxt_s = S_MEM;
                end else begin
                    state_nxt_s = S_FETCH;
                    retire_s    = 1'b1;
                    if (dec_jump) begin
                        pc_we  = 1'b1;
                        pc_src = 2'b01;
                    end else if (dec_branch) begin
                        pc_we  = alu_zero;
                        pc_src = alu_zero ? 2'b10 : 2'b00;
                    end else if (dec_reg_we) begin
                        reg_we = 1'b1;
                    end else if (!dec_mem_we && (ir_r[IW-1 -: 4] != 4'd0)) begin
                        // No decoder control at all on a non-NOP opcode: unsupported
                        illegal_op = 1'b1;
                    end else begin
                        illegal_op = 1'b0;
                    end
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = dec_mem_we & ~dec_reg_we;
                if (mem_ready) begin
                    reg_we      = dec_reg_we & ~dec_mem_we;
                    state_nxt_s = S_FETCH;
                    retire_s    = 1'b1;
                end else begin
                    state_nxt_s = S_MEM;
                end
            end
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    assign ir         = ir_r;
    assign opcode_out = ir_r[IW-1 -: 4];
    assign retired    = retired_r;
    assign halted     = halted_r;
    assign state      = state_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: per-cycle vector table for instruction flows plus
// hand-written sequences for HALT, mid-access reset and retired-counter wrap.
module tb_cpu_sequencer;

    localparam int IW    = 16;
    localparam int CNT_W = 8;   // narrow counter so the wrap is reachable quickly

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [IW-1:0]    mem_rdata;
    logic             mem_ready;
    logic             dec_reg_we, dec_mem_we, dec_mem_addr_sel;
    logic             dec_jump, dec_branch, dec_halt;
    logic             alu_zero;
    logic [3:0]       opcode_out;
    logic [IW-1:0]    ir;
    logic             mem_addr_sel, mem_req, mem_we, reg_we, pc_we;
    logic [1:0]       pc_src;
    logic             halted, illegal_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int checks = 0;
    int errors = 0;

    cpu_sequencer #(.IW(IW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .dec_reg_we(dec_reg_we), .dec_mem_we(dec_mem_we),
        .dec_mem_addr_sel(dec_mem_addr_sel), .dec_jump(dec_jump),
        .dec_branch(dec_branch), .dec_halt(dec_halt), .alu_zero(alu_zero),
        .opcode_out(opcode_out), .ir(ir), .mem_addr_sel(mem_addr_sel),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we), .pc_we(pc_we),
        .pc_src(pc_src), .halted(halted), .illegal_op(illegal_op),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Stand-in instruction decoder: 0 NOP, 1-7 ALU/MOV, 8 LD, 9 ST, A JMP, B BEQZ, E HLT
    always_comb begin
        dec_reg_we       = ((opcode_out >= 4'd1) && (opcode_out <= 4'd7)) || (opcode_out == 4'd8);
        dec_mem_we       = (opcode_out == 4'd9);
        dec_mem_addr_sel = (opcode_out == 4'd8) || (opcode_out == 4'd9);
        dec_jump         = (opcode_out == 4'd10);
        dec_branch       = (opcode_out == 4'd11);
        dec_halt         = (opcode_out == 4'd14);
    end

    typedef struct {
        logic        start;
        logic        rdy;
        logic [15:0] rdata;
        logic        az;
        logic [11:0] exp;
    } vec_t;

    vec_t vq[$];

    // Packed output order: state, halted, pc_we, pc_src, reg_we, mem_we, mem_req, addr_sel, illegal
    function automatic logic [11:0] ex(input logic [2:0] st, input logic h, input logic pw,
                                       input logic [1:0] ps, input logic rw, input logic mw,
                                       input logic rq, input logic as, input logic il);
        return {st, h, pw, ps, rw, mw, rq, as, il};
    endfunction

    function automatic logic [11:0] outs();
        return {state, halted, pc_we, pc_src, reg_we, mem_we, mem_req, mem_addr_sel, illegal_op};
    endfunction

    task automatic add(input logic s, input logic r, input logic [15:0] d, input logic a,
                       input logic [11:0] e);
        vq.push_back('{start: s, rdy: r, rdata: d, az: a, exp: e});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic s, input logic r, input logic [15:0] d, input logic a);
        @(negedge clk);
        start     = s;
        mem_ready = r;
        mem_rdata = d;
        alu_zero  = a;
        #1;
    endtask

    task automatic add_fetch(input logic [15:0] d);
        add(1'b0, 1'b1, d, 1'b0, ex(3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000; alu_zero = 1'b0;

        // IDLE with start pulse
        add(1'b1, 1'b0, 16'h0000, 1'b0, ex(3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        // ADD: reg_we in EXEC
        add_fetch(16'h1240);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        // LD with three wait cycles in MEM
        add_fetch(16'h8123);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            add(1'b0, 1'b0, 16'h0000, 1'b0, ex(3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd4, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0));
        // ST after one fetch wait cycle; single MEM cycle with mem_we
        add(1'b0, 1'b0, 16'h9000, 1'b0, ex(3'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        add_fetch(16'h9000);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        // BEQZ taken, then not taken
        add_fetch(16'hB000);
        add(1'b0, 1'b1, 16'h0000, 1'b1, ex(3'd3, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_fetch(16'hB000);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        // Illegal opcode, NOP, JMP
        add_fetch(16'hC000);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        add_fetch(16'h0000);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        add_fetch(16'hA000);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        // HLT: EXEC has no strobes, then HALT
        add_fetch(16'hE000);
        add(1'b0, 1'b1, 16'h0000, 1'b0, ex(3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'(ex(3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        chk("reset_ir", 32'(ir), 32'h0);
        chk("reset_retired", 32'(retired), 32'h0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            cyc(vq[i].start, vq[i].rdy, vq[i].rdata, vq[i].az);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
            if (i == 2) chk("ir_add", 32'(ir), 32'h1240);
            if (i == 2) chk("opcode_add", 32'(opcode_out), 32'h1);
        end

        // HALT holds for 20 cycles even with start pulses
        for (int i = 0; i < 20; i++) begin
            cyc(i[0], 1'b1, 16'h1240, 1'b1);
            chk($sformatf("halt%0d", i), 32'(outs()),
                32'(ex(3'd5, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        end
        chk("retired_after_hlt", 32'(retired), 32'd9);

        // Reset out of HALT clears everything
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_halt_outs", 32'(outs()), 32'(ex(3'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        chk("rst_halt_retired", 32'(retired), 32'h0);
        chk("rst_halt_ir", 32'(ir), 32'h0);

        // Reset mid-store aborts the pending write immediately
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 16'h9000, 1'b0);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("st_wait_mem_we", 32'({state, mem_we, reg_we}), 32'({3'd4, 1'b1, 1'b0}));
        #1 rst_n = 1'b0;
        #1;
        chk("st_abort", 32'({state, mem_we, mem_req, ir}), 32'({3'd0, 1'b0, 1'b0, 16'h0000}));

        // Retired counter wrap over 2^CNT_W NOPs
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 16'h0000, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            if (i == 255) chk("retired_ff", 32'(retired), 32'hFF);
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
            cyc(1'b0, 1'b1, 16'h0000, 1'b0);
        end
        cyc(1'b0, 1'b0, 16'h0000, 1'b0);
        chk("retired_wrap", 32'(retired), 32'h0);
        chk("wrap_state", 32'(state), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
